// File: rtl/robot_ctrl.sv
// -----------------------------------------------------------------------------
// robot_ctrl
//
// Decision core of the pipe-cleaning robot. Each rising edge of clock_50 is one
// robot step: the world model presents four sensor bits, this block answers
// with at most one command (advance, rotate left, remove trash), and the world
// model executes that command on the same edge.
//
// Navigation is left-hand wall following. A right turn is realised as three
// consecutive left rotations; trash ahead is removed by holding `remove` for
// REMOVE_CYCLES consecutive steps.
//
// Ports:
//   clock_50   in   step clock, one rising edge = one robot step
//   reset_flag in   asynchronous, active-high reset
//   head       in   wall directly ahead
//   left       in   wall on the robot's left
//   under      in   black block under the robot
//   barrier    in   trash directly ahead
//   front      out  advance one cell on this step
//   turn       out  rotate 90 degrees counter-clockwise on this step
//   remove     out  trash-removal pulse on this step
//   state      out  current state encoding (debug / verification)
//
// Parameters:
//   REMOVE_CYCLES    steps `remove` is held per trash item (1..3)
//   RIGHT_TURN_STEPS left rotations per right turn (fixed at 3)
//
// Build option:
//   ROBOT_HALT_ON_UNDER_EN  when defined, a black block under the robot stops
//                           it permanently (until reset). When undefined,
//                           `under` is ignored and HALT is unreachable.
// -----------------------------------------------------------------------------
module robot_ctrl #(
   parameter int REMOVE_CYCLES    = 3,
   parameter int RIGHT_TURN_STEPS = 3
) (
   input  logic       clock_50,
   input  logic       reset_flag,
   input  logic       head,
   input  logic       left,
   input  logic       under,
   input  logic       barrier,
   output logic       front,
   output logic       turn,
   output logic       remove,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_FOLLOW         = 3'd0,
      ST_FWD_AFTER_TURN = 3'd1,
      ST_REMOVE         = 3'd2,
      ST_ROT_RIGHT      = 3'd3,
      ST_HALT           = 3'd4
   } state_t;

   // Last counter value of each multi-step sequence.
   localparam logic [1:0] REMOVE_LAST = 2'(REMOVE_CYCLES - 1);
   localparam logic [1:0] ROT_LAST    = 2'(RIGHT_TURN_STEPS - 1);

   // Bit positions inside the command vector.
   localparam int CMD_FRONT  = 0;
   localparam int CMD_TURN   = 1;
   localparam int CMD_REMOVE = 2;

   generate
      if (REMOVE_CYCLES < 1 || REMOVE_CYCLES > 3) begin : g_bad_remove_cycles
         $error("robot_ctrl: REMOVE_CYCLES must be in 1..3");
      end
      if (RIGHT_TURN_STEPS != 3) begin : g_bad_turn_steps
         $error("robot_ctrl: RIGHT_TURN_STEPS must be 3");
      end
   endgenerate

   state_t     state_reg;
   state_t     state_next;
   logic [1:0] cnt_reg;
   logic [1:0] cnt_next;
   logic [2:0] cmd_next;
   logic [2:0] cmd_out;
   logic       halt_hit;

`ifdef ROBOT_HALT_ON_UNDER_EN
   assign halt_hit = under;
`else
   // The black-floor sensor has no effect in this build.
   logic unused_under;
   assign unused_under = under;
   assign halt_hit     = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Next-state and Mealy command logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      cmd_next   = 3'b000;

      case (state_reg)
         ST_FOLLOW, ST_FWD_AFTER_TURN: begin
            if (halt_hit) begin
               state_next = ST_HALT;
               cnt_next   = 2'd0;
            end else if (barrier) begin
               cmd_next[CMD_REMOVE] = 1'b1;
               if (REMOVE_CYCLES == 1) begin
                  state_next = ST_FOLLOW;
                  cnt_next   = 2'd0;
               end else begin
                  state_next = ST_REMOVE;
                  cnt_next   = 2'd1;
               end
            end else if (state_reg == ST_FOLLOW && !left) begin
               // Opening on the left: turn into it. The follow-up step skips
               // this rule so the robot does not spin in open space.
               cmd_next[CMD_TURN] = 1'b1;
               state_next         = ST_FWD_AFTER_TURN;
               cnt_next           = 2'd0;
            end else if (!head) begin
               cmd_next[CMD_FRONT] = 1'b1;
               state_next          = ST_FOLLOW;
               cnt_next            = 2'd0;
            end else begin
               // Blocked ahead and on the left: begin a right turn, which is
               // three left rotations in a row.
               cmd_next[CMD_TURN] = 1'b1;
               state_next         = ST_ROT_RIGHT;
               cnt_next           = 2'd1;
            end
         end

         ST_REMOVE: begin
            cmd_next[CMD_REMOVE] = 1'b1;
            if (cnt_reg == REMOVE_LAST) begin
               state_next = ST_FOLLOW;
               cnt_next   = 2'd0;
            end else begin
               cnt_next = cnt_reg + 2'd1;
            end
         end

         ST_ROT_RIGHT: begin
            cmd_next[CMD_TURN] = 1'b1;
            if (cnt_reg == ROT_LAST) begin
               state_next = ST_FOLLOW;
               cnt_next   = 2'd0;
            end else begin
               cnt_next = cnt_reg + 2'd1;
            end
         end

         ST_HALT: begin
            state_next = ST_HALT;
            cnt_next   = 2'd0;
         end

         default: begin
            state_next = ST_FOLLOW;
            cnt_next   = 2'd0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clock_50 or posedge reset_flag) begin
      if (reset_flag) begin
         state_reg <= ST_FOLLOW;
         cnt_reg   <= 2'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: commands are forced low while reset is held, so an aborted
   // sequence stops issuing commands immediately, not at the next edge.
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_cmd_gate
         assign cmd_out[gi] = cmd_next[gi] & ~reset_flag;
      end
   endgenerate

   assign front  = cmd_out[CMD_FRONT];
   assign turn   = cmd_out[CMD_TURN];
   assign remove = cmd_out[CMD_REMOVE];
   assign state  = state_reg;

endmodule

// File: tb/tb_robot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_robot_ctrl
//
// Bench for robot_ctrl. A behavioural model tracks the robot in terms of
// "rotations still owed", "removals still owed", "just turned into an opening"
// and "halted", and a compare process checks every step's outputs against it.
// Directed scenarios also pin specific outputs to hand-computed literals.
// -----------------------------------------------------------------------------
module tb_robot_ctrl;

   localparam int RC = 3;

   logic       clock_50   = 1'b0;
   logic       reset_flag = 1'b1;
   logic       head       = 1'b0;
   logic       left       = 1'b1;
   logic       under      = 1'b0;
   logic       barrier    = 1'b0;
   logic       front;
   logic       turn;
   logic       remove;
   logic [2:0] state;

   robot_ctrl #(
      .REMOVE_CYCLES    (RC),
      .RIGHT_TURN_STEPS (3)
   ) dut (
      .clock_50   (clock_50),
      .reset_flag (reset_flag),
      .head       (head),
      .left       (left),
      .under      (under),
      .barrier    (barrier),
      .front      (front),
      .turn       (turn),
      .remove     (remove),
      .state      (state)
   );

   always #10 clock_50 = ~clock_50;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model
   // ---------------------------------------------------------------------------
   bit m_halted       = 1'b0;
   bit m_after_turn   = 1'b0;
   int m_turns_left   = 0;
   int m_removes_left = 0;
   int exp_front, exp_turn, exp_remove, exp_state;
   bit halt_rule;

   always @(negedge clock_50) begin
      #1;
      exp_front  = 0;
      exp_turn   = 0;
      exp_remove = 0;
      if (reset_flag) begin
         m_halted       = 1'b0;
         m_after_turn   = 1'b0;
         m_turns_left   = 0;
         m_removes_left = 0;
         exp_state      = 0;
      end else begin
         if (m_halted)                exp_state = 4;
         else if (m_turns_left > 0)   exp_state = 3;
         else if (m_removes_left > 0) exp_state = 2;
         else if (m_after_turn)       exp_state = 1;
         else                         exp_state = 0;

`ifdef ROBOT_HALT_ON_UNDER_EN
         halt_rule = under;
`else
         halt_rule = 1'b0;
`endif
         // The model advances here; inputs stay stable until after the
         // next rising edge, so this is the step the DUT takes on that edge.
         if (m_halted) begin
         end else if (m_turns_left > 0) begin
            exp_turn = 1;
            m_turns_left--;
         end else if (m_removes_left > 0) begin
            exp_remove = 1;
            m_removes_left--;
         end else if (halt_rule) begin
            m_halted = 1'b1;
         end else if (barrier) begin
            exp_remove     = 1;
            m_removes_left = RC - 1;
            m_after_turn   = 1'b0;
         end else if (!left && !m_after_turn) begin
            exp_turn     = 1;
            m_after_turn = 1'b1;
         end else if (!head) begin
            exp_front    = 1;
            m_after_turn = 1'b0;
         end else begin
            exp_turn     = 1;
            m_turns_left = 2;
            m_after_turn = 1'b0;
         end
      end
      check("model_front",  int'(front),  exp_front);
      check("model_turn",   int'(turn),   exp_turn);
      check("model_remove", int'(remove), exp_remove);
      check("model_state",  int'(state),  exp_state);
      check("model_onehot", int'(front) + int'(turn) + int'(remove) <= 1 ? 1 : 0, 1);
   end

   // ---------------------------------------------------------------------------
   // Stimulus: drive just after a rising edge, look after the falling edge.
   // ---------------------------------------------------------------------------
   task automatic apply(input bit r, input bit h, input bit l, input bit u, input bit b);
      @(posedge clock_50);
      #1;
      reset_flag = r;
      head       = h;
      left       = l;
      under      = u;
      barrier    = b;
      @(negedge clock_50);
      #2;
      $display("step r=%0d h=%0d l=%0d u=%0d b=%0d -> front=%0d turn=%0d remove=%0d state=%0d",
               r, h, l, u, b, front, turn, remove, state);
   endtask

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic lit(input string name, input int f, input int t, input int rm, input int s);
      check({name, "_front"},  int'(front),  f);
      check({name, "_turn"},   int'(turn),   t);
      check({name, "_remove"}, int'(remove), rm);
      check({name, "_state"},  int'(state),  s);
   endtask

   initial begin
      // Reset with random sensors
      apply(1, rb(), rb(), rb(), rb());
      lit("reset", 0, 0, 0, 0);
      apply(0, 0, 1, 0, 0);
      lit("first_step", 1, 0, 0, 0);

      // Left opening
      apply(0, 0, 0, 0, 0);
      lit("open_turn", 0, 1, 0, 0);
      apply(0, 0, 0, 0, 0);
      lit("open_fwd", 1, 0, 0, 1);
      apply(0, 0, 1, 0, 0);
      lit("open_back", 1, 0, 0, 0);

      // Dead corner: three rotations, sensors random during the sequence
      apply(0, 1, 1, 0, 0);
      lit("corner_1", 0, 1, 0, 0);
      apply(0, rb(), rb(), rb(), rb());
      lit("corner_2", 0, 1, 0, 3);
      apply(0, rb(), rb(), rb(), rb());
      lit("corner_3", 0, 1, 0, 3);
      apply(0, 0, 1, 0, 0);
      lit("corner_done", 1, 0, 0, 0);

      // Trash: barrier drops after the first step
      apply(0, 0, 1, 0, 1);
      lit("trash_1", 0, 0, 1, 0);
      apply(0, 0, 1, 0, 0);
      lit("trash_2", 0, 0, 1, 2);
      apply(0, 0, 1, 0, 0);
      lit("trash_3", 0, 0, 1, 2);
      apply(0, 0, 1, 0, 0);
      lit("trash_done", 1, 0, 0, 0);

      // Reset after the second rotation
      apply(0, 1, 1, 0, 0);
      lit("abort_1", 0, 1, 0, 0);
      apply(0, 1, 1, 0, 0);
      lit("abort_2", 0, 1, 0, 3);
      apply(1, 1, 1, 0, 0);
      lit("abort_rst", 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0);
      lit("abort_follow", 0, 1, 0, 0);

      // Random walk, model-checked, with occasional resets
      for (int i = 0; i < 80; i++) begin
         apply(1'($urandom_range(0, 15) == 0), rb(), rb(),
               1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 3) == 0));
      end

      // Halt: under and barrier together
      apply(1, 0, 1, 0, 0);
      apply(0, 0, 1, 0, 0);
      lit("pre_halt", 1, 0, 0, 0);
      apply(0, 0, 1, 1, 1);
`ifdef ROBOT_HALT_ON_UNDER_EN
      lit("halt_enter", 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         apply(0, rb(), rb(), rb(), rb());
         lit("halt_hold", 0, 0, 0, 4);
      end
      apply(1, 0, 1, 0, 0);
      lit("halt_rst", 0, 0, 0, 0);
      apply(0, 0, 1, 0, 0);
      lit("halt_after", 1, 0, 0, 0);
`else
      lit("under_ignored", 0, 0, 1, 0);
      apply(0, 0, 1, 1, 0);
      lit("under_rm2", 0, 0, 1, 2);
      apply(0, 0, 1, 1, 0);
      lit("under_rm3", 0, 0, 1, 2);
      apply(0, 0, 1, 1, 0);
      lit("under_fwd", 1, 0, 0, 0);
`endif

      @(posedge clock_50);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
